imem_loader: RTL

//  Write-side counterpart of the instruction memory. Receives a program as a byte stream
//  (e.g. from a UART RX), packs each group of 4 bytes MSB-first into a 32-bit instruction,
//  and writes the instructions to consecutive instruction-RAM addresses from 0.

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs 4 bytes MSB-first per word, writes words from address 0,
// holds the CPU until the END word is written. Optional NOP fill above END: IMEM_LOADER_PAD_EN.
module imem_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD = 32'hF800_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

`ifdef IMEM_LOADER_PAD_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_PAD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t              state_r, state_n;
  logic [1:0]          cnt_r, cnt_n;
  logic [31:0]         sh_r, sh_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic [ADDR_W:0]     wc_r, wc_n;
  logic                err_r, err_n;
  logic                byte_ready_r, we_r, cpu_hold_r, done_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [31:0]         wdata_r;
  logic                pad_n;

  // Next-state and datapath updates; a byte is taken only while in RECV (byte_ready high).
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    sh_n    = sh_r;
    addr_n  = addr_r;
    wc_n    = wc_r;
    err_n   = err_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_RECV;
          cnt_n   = 2'd0;
          sh_n    = 32'd0;
          addr_n  = {ADDR_W{1'b0}};
          wc_n    = {(ADDR_W+1){1'b0}};
          err_n   = 1'b0;
        end else begin
          state_n = state_r;
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          sh_n  = {sh_r[23:0], byte_data};
          cnt_n = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_n = S_WRITE;
          end else begin
            state_n = S_RECV;
          end
        end else begin
          state_n = S_RECV;
        end
      end
      S_WRITE: begin
        wc_n = wc_r + {{ADDR_W{1'b0}}, 1'b1};
        if (sh_r == END_WORD) begin
`ifdef IMEM_LOADER_PAD_EN
          if (addr_r == LAST_ADDR) begin
            state_n = S_DONE;
          end else begin
            addr_n  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_n = S_PAD;
          end
`else
          state_n = S_DONE;
`endif
        end else if (addr_r == LAST_ADDR) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          addr_n  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_n = S_RECV;
        end
      end
`ifdef IMEM_LOADER_PAD_EN
      S_PAD: begin
        if (addr_r == LAST_ADDR) begin
          state_n = S_DONE;
        end else begin
          addr_n  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_n = S_PAD;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Decode of the NOP-fill state for the registered write data.
  always_comb begin
`ifdef IMEM_LOADER_PAD_EN
    if (state_n == S_PAD) begin
      pad_n = 1'b1;
    end else begin
      pad_n = 1'b0;
    end
`else
    pad_n = 1'b0;
`endif
  end

  // State, datapath and output registers; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 2'd0;
      sh_r         <= 32'd0;
      addr_r       <= {ADDR_W{1'b0}};
      wc_r         <= {(ADDR_W+1){1'b0}};
      err_r        <= 1'b0;
      byte_ready_r <= 1'b0;
      we_r         <= 1'b0;
      waddr_r      <= {ADDR_W{1'b0}};
      wdata_r      <= 32'd0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      sh_r         <= sh_n;
      addr_r       <= addr_n;
      wc_r         <= wc_n;
      err_r        <= err_n;
      byte_ready_r <= (state_n == S_RECV);
      we_r         <= (state_n == S_WRITE) || pad_n;
      waddr_r      <= addr_n;
      wdata_r      <= pad_n ? NOP_WORD : sh_n;
      cpu_hold_r   <= (state_n != S_DONE);
      done_r       <= (state_n == S_DONE);
    end
  end

  assign byte_ready   = byte_ready_r;
  assign we           = we_r;
  assign waddr        = waddr_r;
  assign wdata        = wdata_r;
  assign cpu_hold     = cpu_hold_r;
  assign done         = done_r;
  assign err_overflow = err_r;
  assign word_count   = wc_r;

endmodule
